// File: rtl/ff_conv_pkg.sv
// Shared types for the flip-flop conversion bank.
package ff_conv_pkg;

  typedef enum logic [1:0] {
    MODE_D  = 2'b00,
    MODE_T  = 2'b01,
    MODE_SR = 2'b10,
    MODE_JK = 2'b11
  } ff_mode_t;

  localparam ff_mode_t MODE_RESET = MODE_D;

endpackage

// File: rtl/ff_conv_cell.sv
// One storage channel: mode register, next-state mux, q register and
// raw SR forbidden-input detect.
module ff_conv_cell
  import ff_conv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       a,
  input  logic       b,
  input  logic       wr,
  input  logic [1:0] wr_val,
  output logic       q,
  output logic [1:0] mode,
  output logic       forbid
);

  ff_mode_t mode_r;
  logic     q_next;

  // Next q from the mode currently held; a same-edge mode write is not seen yet
  always_comb begin
    q_next = q;
    unique case (mode_r)
      MODE_D:  q_next = a;
      MODE_T:  q_next = q ^ a;
      MODE_SR: begin
        if (a && !b)      q_next = 1'b1;
        else if (!a && b) q_next = 1'b0;
      end
      MODE_JK: begin
        if (a && !b)      q_next = 1'b1;
        else if (!a && b) q_next = 1'b0;
        else if (a && b)  q_next = ~q;
      end
      default: q_next = q;
    endcase
  end

  // Mode register and q register; the mode path ignores the clock enable
  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_r <= MODE_RESET;
      q      <= 1'b0;
    end else begin
      if (wr) mode_r <= ff_mode_t'(wr_val);
      if (en) q <= q_next;
    end
  end

  assign mode   = mode_r;
  assign forbid = en && (mode_r == MODE_SR) && a && b;

endmodule

// File: rtl/ff_conv_bank.sv
// Bank of WIDTH run-time selectable D/T/SR/JK flip-flops with sticky
// SR forbidden-input flags. Define FF_CONV_ERRCNT_EN to build the
// saturating error-event counter; otherwise err_cnt is tied to zero.
module ff_conv_bank
  import ff_conv_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic                     mode_wr,
  input  logic [$clog2(WIDTH)-1:0] mode_sel,
  input  logic [1:0]               mode_val,
  input  logic                     err_clr,
  output logic [WIDTH-1:0]         q,
  output logic [WIDTH-1:0]         qb,
  output logic [WIDTH-1:0]         illegal,
  output logic [2*WIDTH-1:0]       mode,
  output logic [CNT_W-1:0]         err_cnt
);

  localparam int SEL_W = $clog2(WIDTH);

  logic [WIDTH-1:0] forbid;

  // Out-of-range selects match no cell, so the write is dropped
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_conv_cell u_cell (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .a      (a[i]),
      .b      (b[i]),
      .wr     (mode_wr && (mode_sel == SEL_W'(i))),
      .wr_val (mode_val),
      .q      (q[i]),
      .mode   (mode[2*i+1:2*i]),
      .forbid (forbid[i])
    );
  end

  assign qb = ~q;

  // Sticky flags; a new forbidden input outranks a same-edge clear
  always_ff @(posedge clk) begin
    if (!rst) illegal <= '0;
    else      illegal <= (err_clr ? '0 : illegal) | forbid;
  end

`ifdef FF_CONV_ERRCNT_EN
  logic err_event;
  assign err_event = |forbid;

  // One count per event edge regardless of channel count; clear then count
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= err_event ? CNT_W'(1) : '0;
    end else if (err_event && (err_cnt != '1)) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: doc/ff_conv_bank.md
# ff_conv_bank

Parametrised bank of `WIDTH` independent single-bit storage channels built on D-type registers. Each channel runs as a D, T, SR or JK flip-flop, selected at run time by a per-channel mode register, so one block replaces the individual flip-flop conversion circuits. The block adds a shared clock enable, sticky per-channel detection of the SR forbidden input (S=R=1), and an optional saturating error counter. It sits wherever the design needs mixed flip-flop types under software or FSM control.

## Interface
- `WIDTH`, 8: number of channels. Minimum 2.
- `CNT_W`, 8: width of the error counter.
- `clk` in, 1: single clock; all state updates on the rising edge.
- `rst` in, 1: synchronous, active-low reset.
- `en` in, 1: clock enable for all `q` updates. The mode write path and the error-clear path do not depend on it.
- `a` in, `WIDTH`: first data input per channel. It is D in D mode, T in T mode, S in SR mode and J in JK mode.
- `b` in, `WIDTH`: second data input per channel. It is R in SR mode and K in JK mode. It is ignored in D and T modes.
- `mode_wr` in, 1: strobe to write one channel's mode.
- `mode_sel` in, `$clog2(WIDTH)`: index of the channel to write. If the index is ≥ `WIDTH`, the write is dropped.
- `mode_val` in, 2: mode to write. 00 = D, 01 = T, 10 = SR, 11 = JK.
- `err_clr` in, 1: clears all `illegal` flags and `err_cnt`.
- `q` out, `WIDTH`: registered state of each channel.
- `qb` out, `WIDTH`: always equal to `~q`.
- `illegal` out, `WIDTH`: sticky flag per channel, set on an SR forbidden input.
- `mode` out, `2*WIDTH`: current mode of every channel. Channel i occupies bits [2i+1:2i].
- `err_cnt` out, `CNT_W`: saturating count of forbidden-input cycles.

## Operation
- Reset (`rst`=0 at a clock edge) drives these values:
  - `q`=0 and `qb`=all ones.
  - Every mode = D.
  - `illegal`=0 and `err_cnt`=0.
  - Reset overrides every other input in the same cycle.
- When `en`=1, each channel i computes its next `q` from its current mode:
  - D: q ← a.
  - T: q ← q ^ a.
  - SR: 10 → 1, 01 → 0, 00 → hold, 11 → hold. The 11 case also sets `illegal[i]`.
  - JK: 10 → 1, 01 → 0, 00 → hold, 11 → toggle. JK never flags.
- When `en`=0, `q` holds for every channel, and no forbidden input is detected.
- A mode write lands at the edge where `mode_wr`=1. The new mode governs `q` from the following edge onward.
  - If the same edge writes the mode and updates `q`, the `q` update uses the old mode.
- Error event: one edge with `en`=1 at which at least one SR-mode channel sees a=b=1.
  - Each error event increments `err_cnt` by exactly 1, no matter how many channels are in the forbidden state.
  - `err_cnt` saturates at 2^`CNT_W`−1.
- `err_clr` at an edge clears `illegal` and `err_cnt`.
  - If an error event occurs at the same edge, the new event wins. The flagged channels' `illegal` bits end at 1, all other bits at 0, and `err_cnt` ends at 1.
- Changing a channel's mode does not clear its `illegal` bit.

## Timing
- All outputs are registered, except `qb`, which is the combinational inverse of `q`.
- Latency from inputs to `q`: 1 edge.
- `mode_wr` to the new `mode` value: 1 edge. The new mode affects `q` from the 2nd edge.
- Error event to `illegal` and `err_cnt`: 1 edge.
- There is no handshake. Every input is sampled at each edge.

## Configuration
- `FF_CONV_ERRCNT_EN` defined: the `err_cnt` counter and its increment and saturate logic are built as described above.
- `FF_CONV_ERRCNT_EN` undefined: the counter logic is removed and `err_cnt` is tied to 0, so the port list does not change.
  - The `illegal` flags and the `err_clr` behaviour on them are unaffected.

## Structure
- Package `ff_conv_pkg` holds:
  - `ff_mode_t`, a 2-bit enum with values `MODE_D`, `MODE_T`, `MODE_SR`, `MODE_JK`.
  - `MODE_RESET` = `MODE_D`.
- Sub-module `ff_conv_cell` implements one channel: the mode register, the next-state mux, the `q` register and the raw forbidden-input detect.
- The top level generates `WIDTH` cells, decodes `mode_sel`, and holds the `illegal` vector and the counter.

## Test plan
- Reset check: hold `rst`=0 with random inputs and `en`=1 → `q`=0, `qb`=all ones, every mode = D, `illegal`=0, `err_cnt`=0.
- D mode: with `WIDTH`=8 and every channel in D, drive `a`=8'hA5 with `en`=1 → `q`=8'hA5 after one edge. Then drive `en`=0 and `a`=8'h00 → `q` stays 8'hA5.
- T and JK modes:
  - Set channel 0 to T and drive `a[0]`=1 for 4 edges → `q[0]` reads 1, 0, 1, 0.
  - Set channel 1 to JK with j=k=1 → `q[1]` toggles each edge.
  - Drive j=1, k=0 → `q[1]`=1.
- SR forbidden input: set channel 2 to SR, drive s=1, r=0, then s=r=1 for 3 edges.
  - `q[2]` reads 1 and then holds at 1.
  - `illegal[2]`=1.
  - `err_cnt`=3 with the macro defined, and 0 without it.
- Mode timing: at the same edge, write channel 3 to T and drive `a[3]`=1 with `q[3]`=0 → the D rule applies and `q[3]`=1. At the next edge with `a[3]`=1 → `q[3]`=0.
- Clear and saturation:
  - With `CNT_W`=2, run 5 error events → `err_cnt`=3.
  - Assert `err_clr` at the same edge as an error event → `err_cnt`=1 and only the offending channel's `illegal` bit is set.
